// File: rtl/bus_master_port.sv
// Purpose: initiator port of the 2-master/3-slave serial bus; turns a parallel write into request/address/data.
// Latency: with a free bus and a ready slave, done pulses DATA_WIDTH+5 cycles after the start cycle.
// Backpressure: a start is ignored while busy; the data bit is held whenever m_ready=0; waiting for the first ready is bounded by TIMEOUT.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, slave_sel,     command strobe, target slave (3 is illegal) and data word;
//   wdata                 all are captured when start is accepted
//   busy, done, error     command status toward local logic (done/error are one-cycle pulses)
//   m_request, m_address_valid, m_address, m_data, m_valid   serial protocol toward the arbiter
//   m_ready, m_available  slave ready and bus-free indication from the arbiter
module bus_master_port #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            slave_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  m_request,
  output logic                  m_address_valid,
  output logic                  m_address,
  output logic                  m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  m_available
);

  typedef enum logic [3:0] {
    IDLE, WAIT_BUS, REQ, ADDR1, ADDR2, CONNECT, WAIT_READY, DATA, RELEASE
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            sel_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  err_q;

  logic accept;
  logic illegal;
  logic xfer;
  logic tmo_hit;
  logic last_bit;

  assign accept   = (state == IDLE) && start;
  assign illegal  = (slave_sel == 2'd3);
  assign xfer     = ((state == WAIT_READY) || (state == DATA)) && m_ready;
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  // bit_cnt counts completed transfers, so the transfer in progress is the last
  // one when DATA_WIDTH-1 have already gone out.
  assign last_bit = (bit_cnt == CNT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel_q   <= 2'd0;
      shift_q <= '0;
      bit_cnt <= '0;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      // error is registered so it appears the cycle after the offending start
      // or the last unanswered WAIT_READY cycle, while the FSM is already idle.
      err_q <= (accept && illegal) ||
               ((state == WAIT_READY) && !m_ready && tmo_hit);

      if (accept) begin
        sel_q   <= slave_sel;
        shift_q <= wdata;
      end else if (xfer) begin
        shift_q <= shift_q << 1;
      end

      if (state == CONNECT) begin
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        if (xfer) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
        if ((state == WAIT_READY) && !m_ready) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    busy            = (state != IDLE);
    done            = 1'b0;
    error           = err_q;
    m_request       = 1'b0;
    m_address_valid = 1'b0;
    m_address       = 1'b0;
    m_data          = 1'b0;
    m_valid         = 1'b0;

    case (state)
      IDLE: begin
        // A free bus lets the request go out on the cycle right after start.
        if (start && !illegal) begin
          state_nxt = m_available ? REQ : WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        if (m_available) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        m_request       = 1'b1;
        m_address_valid = 1'b1;
        state_nxt       = ADDR1;
      end
      ADDR1: begin
        // Losing arbitration here withdraws the request in the same cycle.
        if (m_available) begin
          m_request = 1'b1;
          m_address = sel_q[1];
          state_nxt = ADDR2;
        end else begin
          state_nxt = WAIT_BUS;
        end
      end
      ADDR2: begin
        m_request = 1'b1;
        m_address = sel_q[0];
        state_nxt = CONNECT;
      end
      CONNECT: begin
        m_request = 1'b1;
        state_nxt = WAIT_READY;
      end
      WAIT_READY: begin
        m_request = 1'b1;
        m_valid   = 1'b1;
        m_data    = shift_q[DATA_WIDTH-1];
        if (m_ready) begin
          state_nxt = (DATA_WIDTH == 1) ? RELEASE : DATA;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        m_request = 1'b1;
        m_valid   = 1'b1;
        m_data    = shift_q[DATA_WIDTH-1];
        if (m_ready && last_bit) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_master_port.sv
module tb_bus_master_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] slave_sel;
  logic [7:0] wdata;
  logic       busy, done, error;
  logic       m_request, m_address_valid, m_address, m_data, m_valid;
  logic       m_ready, m_available;

  int n_checks = 0;
  int n_pass   = 0;

  bus_master_port #(.DATA_WIDTH(8), .TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .slave_sel(slave_sel), .wdata(wdata),
    .busy(busy), .done(done), .error(error),
    .m_request(m_request), .m_address_valid(m_address_valid), .m_address(m_address),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_available(m_available)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req"}, m_request, 0);
    check({tag, "_valid"}, m_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, error, 0);
  endtask

  // Runs a transfer until done, collecting bits on m_valid&&m_ready cycles.
  // With toggle_rdy the slave answers 1,0,1,0... once m_valid is up and the
  // held bit is checked on every stall cycle against the expected word.
  task automatic run_xfer(input bit toggle_rdy, input logic [7:0] exp_w,
                          output logic [7:0] word, output int nxfer,
                          output bit got_done, output int gap);
    bit r;
    int last_k;
    r = 1'b1; word = '0; nxfer = 0; got_done = 1'b0; gap = -1; last_k = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 200 && !got_done; k++) begin
      tick();
      start = 1'b0;
      if (m_valid) begin
        m_ready = r;
        #1;
        if (m_ready) begin
          word   = {word[6:0], m_data};
          nxfer++;
          last_k = k;
        end else if (nxfer < 8) begin
          check("hold_bit", m_data, exp_w[7-nxfer]);
        end
        if (toggle_rdy) r = !r;
      end else if (done) begin
        got_done = 1'b1;
        gap      = k - last_k;
        check("done_req_low", m_request, 0);
      end
    end
    m_ready = 1'b1;
  endtask

  logic [7:0] w, word;
  int         nxfer, gap, nvalid;
  bit         got_done, got_err;

  initial begin
    reset = 1'b1; start = 1'b0; slave_sel = 2'd0; wdata = 8'h00;
    m_ready = 1'b1; m_available = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    check("reset_addr", m_address, 0);
    reset = 1'b0;
    tick();

    // 1: sel=1, A5, free bus, slave always ready; explicit cycle-by-cycle view.
    w = 8'hA5;
    start = 1'b1; slave_sel = 2'd1; wdata = w;
    tick();
    start = 1'b0;
    check("t0_req", m_request, 1);
    check("t0_av", m_address_valid, 1);
    check("t0_busy", busy, 1);
    tick();
    check("t1_req", m_request, 1);
    check("t1_av", m_address_valid, 0);
    check("t1_addr", m_address, 0);
    tick();
    check("t2_addr", m_address, 1);
    tick();
    check("t3_req", m_request, 1);
    check("t3_addr", m_address, 0);
    check("t3_valid", m_valid, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t1_valid", m_valid, 1);
      check("t1_bit", m_data, w[7-i]);
      check("t1_nodone", done, 0);
    end
    tick();
    check("t12_done", done, 1);
    check("t12_req", m_request, 0);
    check("t12_valid", m_valid, 0);
    check("t12_err", error, 0);
    tick();
    check("t13_busy", busy, 0);
    check("t13_done", done, 0);

    // 2: illegal select gives an error pulse the next cycle and no bus activity.
    start = 1'b1; slave_sel = 2'd3; wdata = 8'h11;
    #1;
    check("ill_err_pre", error, 0);
    tick();
    start = 1'b0;
    check("ill_err", error, 1);
    check("ill_busy", busy, 0);
    check("ill_req", m_request, 0);
    tick();
    check("ill_err_gone", error, 0);
    check("ill_req2", m_request, 0);

    // 3: bus held by the other master for 5 cycles; a start while busy is ignored.
    m_available = 1'b0;
    start = 1'b1; slave_sel = 2'd2; wdata = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = (i == 1);
      slave_sel = (i == 1) ? 2'd3 : 2'd2;
      check("wb_req", m_request, 0);
      check("wb_busy", busy, 1);
      if (i == 2) check("wb_ignored_start", error, 0);
    end
    start = 1'b0;
    m_available = 1'b1;
    tick();
    check("wb_t0_req", m_request, 1);
    check("wb_t0_av", m_address_valid, 1);
    tick();
    check("wb_t1_addr", m_address, 1);
    tick();
    check("wb_t2_addr", m_address, 0);
    run_xfer(1'b0, 8'h3C, word, nxfer, got_done, gap);
    check("wb_done", got_done, 1);
    check("wb_word", word, 8'h3C);
    check("wb_nxfer", nxfer, 8);
    tick();

    // 4: slave never ready -> 16 cycles of m_valid then error.
    m_ready = 1'b0;
    start = 1'b1; slave_sel = 2'd0; wdata = 8'hFF;
    nvalid = 0; got_err = 1'b0;
    for (int k = 0; k < 60 && !got_err; k++) begin
      tick();
      start = 1'b0;
      if (m_valid) nvalid++;
      if (error) got_err = 1'b1;
    end
    check("tmo_err", got_err, 1);
    check("tmo_valid_cycles", nvalid, 16);
    check("tmo_req", m_request, 0);
    check("tmo_busy", busy, 0);
    check("tmo_done", done, 0);
    m_ready = 1'b1;
    tick();
    check("tmo_err_gone", error, 0);

    // 5: F0 with the slave toggling ready; bits held on stalls.
    start = 1'b1; slave_sel = 2'd1; wdata = 8'hF0;
    run_xfer(1'b1, 8'hF0, word, nxfer, got_done, gap);
    check("tog_done", got_done, 1);
    check("tog_word", word, 8'hF0);
    check("tog_nxfer", nxfer, 8);
    check("tog_gap", gap, 1);
    tick();

    // 6: reset during the third data bit, then a clean transfer.
    start = 1'b1; slave_sel = 2'd1; wdata = 8'hFF;
    for (int i = 0; i < 7; i++) begin
      tick();
      start = 1'b0;
    end
    check("rst_in_data", m_valid, 1);
    reset = 1'b1;
    tick();
    check_quiet("rst_mid");
    reset = 1'b0;
    tick();
    check("rst_no_done", done, 0);
    start = 1'b1; slave_sel = 2'd2; wdata = 8'h5A;
    run_xfer(1'b0, 8'h5A, word, nxfer, got_done, gap);
    check("rst_after_done", got_done, 1);
    check("rst_after_word", word, 8'h5A);
    check("rst_after_gap", gap, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
